// File: rtl/cam_lookup_ctrl.sv
// Request-side controller for a 32-entry CAM: searches each key, optionally
// allocates on miss with oldest-first replacement, and returns hit/index.
module cam_lookup_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [WIDTH-1:0]      req_key_i,
    input  logic                  req_insert_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic                  rsp_inserted_o,
    output logic [ADDR_WIDTH-1:0] rsp_index_o,
    output logic                  cam_search_enable_o,
    output logic [WIDTH-1:0]      cam_search_data_o,
    input  logic                  cam_search_valid_i,
    input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
    output logic                  cam_write_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [WIDTH-1:0]      cam_write_data_o,
    output logic [ADDR_WIDTH:0]   occupancy_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [WIDTH-1:0]      key_q;
    logic                  insert_q;
    logic [ADDR_WIDTH-1:0] victim_q;
    logic [ADDR_WIDTH:0]   occ_q;
    logic                  hit_q;
    logic                  inserted_q;
    logic [ADDR_WIDTH-1:0] index_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (!cam_search_valid_i && insert_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                end
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; data/index ports always show latched values.
    // req_ready_o is also masked by rst_i so it reads 0 throughout reset.
    always_comb begin
        req_ready_o         = 1'b0;
        rsp_valid_o         = 1'b0;
        cam_search_enable_o = 1'b0;
        cam_write_enable_o  = 1'b0;
        case (state_q)
            IDLE:    req_ready_o         = !rst_i;
            SEARCH:  cam_search_enable_o = 1'b1;
            WRITE:   cam_write_enable_o  = 1'b1;
            RESP:    rsp_valid_o         = 1'b1;
            default: req_ready_o         = 1'b0;
        endcase
        cam_search_data_o = key_q;
        cam_write_data_o  = key_q;
        cam_write_index_o = victim_q;
        rsp_hit_o         = hit_q;
        rsp_inserted_o    = inserted_q;
        rsp_index_o       = index_q;
        occupancy_o       = occ_q;
    end

    // Request latch, response fields, and FIFO replacement bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_q      <= '0;
            insert_q   <= 1'b0;
            victim_q   <= '0;
            occ_q      <= '0;
            hit_q      <= 1'b0;
            inserted_q <= 1'b0;
            index_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        key_q    <= req_key_i;
                        insert_q <= req_insert_i;
                    end
                end
                SEARCH: begin
                    hit_q      <= cam_search_valid_i;
                    inserted_q <= 1'b0;
                    index_q    <= cam_search_valid_i ? cam_search_index_i : '0;
                end
                WRITE: begin
                    hit_q      <= 1'b0;
                    inserted_q <= 1'b1;
                    index_q    <= victim_q;
                    victim_q   <= victim_q + ADDR_WIDTH'(1);
                    if (occ_q != (ADDR_WIDTH+1)'(DEPTH)) begin
                        occ_q <= occ_q + (ADDR_WIDTH+1)'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Directed bench for cam_lookup_ctrl with a behavioural 32-entry CAM attached.
module tb_cam_lookup_ctrl;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [WIDTH-1:0]      req_key_i;
    logic                  req_insert_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic                  rsp_hit_o;
    logic                  rsp_inserted_o;
    logic [ADDR_WIDTH-1:0] rsp_index_o;
    logic                  cam_search_enable_o;
    logic [WIDTH-1:0]      cam_search_data_o;
    logic                  cam_search_valid_i;
    logic [ADDR_WIDTH-1:0] cam_search_index_i;
    logic                  cam_write_enable_o;
    logic [ADDR_WIDTH-1:0] cam_write_index_o;
    logic [WIDTH-1:0]      cam_write_data_o;
    logic [ADDR_WIDTH:0]   occupancy_o;

    int compared = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    cam_lookup_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_key_i           (req_key_i),
        .req_insert_i        (req_insert_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_hit_o           (rsp_hit_o),
        .rsp_inserted_o      (rsp_inserted_o),
        .rsp_index_o         (rsp_index_o),
        .cam_search_enable_o (cam_search_enable_o),
        .cam_search_data_o   (cam_search_data_o),
        .cam_search_valid_i  (cam_search_valid_i),
        .cam_search_index_i  (cam_search_index_i),
        .cam_write_enable_o  (cam_write_enable_o),
        .cam_write_index_o   (cam_write_index_o),
        .cam_write_data_o    (cam_write_data_o),
        .occupancy_o         (occupancy_o)
    );

    // Attached CAM: rows written on the write strobe, cleared by reset
    logic [WIDTH-1:0] cam_data  [DEPTH];
    logic [DEPTH-1:0] cam_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cam_valid <= '0;
        end else if (cam_write_enable_o) begin
            cam_data[cam_write_index_o]  <= cam_write_data_o;
            cam_valid[cam_write_index_o] <= 1'b1;
        end
    end

    always_comb begin
        cam_search_valid_i = 1'b0;
        cam_search_index_i = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cam_valid[i] && cam_data[i] == cam_search_data_o) begin
                cam_search_valid_i = 1'b1;
                cam_search_index_i = ADDR_WIDTH'(i);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction with cycle-exact checks of every stage
    task automatic transact(input string tag, input logic [WIDTH-1:0] key, input logic ins,
                            input logic exp_hit, input logic exp_ins,
                            input logic [ADDR_WIDTH-1:0] exp_idx, input logic [ADDR_WIDTH:0] exp_occ);
        @(negedge clk_i);
        chk({tag, ".ready"}, 64'(req_ready_o), 64'd1);
        req_valid_i  = 1'b1;
        req_key_i    = key;
        req_insert_i = ins;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk({tag, ".srch_en"}, 64'(cam_search_enable_o), 64'd1);
        chk({tag, ".srch_key"}, 64'(cam_search_data_o), 64'(key));
        chk({tag, ".early_rsp"}, 64'(rsp_valid_o), 64'd0);
        @(posedge clk_i); #1;
        chk({tag, ".wr_en"}, 64'(cam_write_enable_o), 64'(exp_ins));
        if (exp_ins) begin
            chk({tag, ".wr_idx"}, 64'(cam_write_index_o), 64'(exp_idx));
            chk({tag, ".wr_data"}, 64'(cam_write_data_o), 64'(key));
            @(posedge clk_i); #1;
        end
        chk({tag, ".rsp_valid"}, 64'(rsp_valid_o), 64'd1);
        chk({tag, ".hit"}, 64'(rsp_hit_o), 64'(exp_hit));
        chk({tag, ".inserted"}, 64'(rsp_inserted_o), 64'(exp_ins));
        chk({tag, ".index"}, 64'(rsp_index_o), 64'(exp_idx));
        chk({tag, ".occ"}, 64'(occupancy_o), 64'(exp_occ));
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        chk({tag, ".rsp_done"}, 64'(rsp_valid_o), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("rst.ready", 64'(req_ready_o), 64'd0);
        chk("rst.occ", 64'(occupancy_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst.ready_after", 64'(req_ready_o), 64'd1);
    endtask

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_key_i    = '0;
        req_insert_i = 1'b0;
        rsp_ready_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("init.ready", 64'(req_ready_o), 64'd0);
        chk("init.rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("init.srch_en", 64'(cam_search_enable_o), 64'd0);
        chk("init.wr_en", 64'(cam_write_enable_o), 64'd0);
        chk("init.occ", 64'(occupancy_o), 64'd0);
        chk("init.wr_idx", 64'(cam_write_index_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("init.ready_after", 64'(req_ready_o), 64'd1);

        transact("ins_deadbeef", 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 5'd0, 6'd1);
        transact("look_deadbeef", 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd0, 6'd1);
        transact("look_absent", 32'h12345678, 1'b0, 1'b0, 1'b0, 5'd0, 6'd1);
        transact("ins_dup", 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 5'd0, 6'd1);

        // Fill past capacity: 33rd key overwrites the oldest row
        do_reset();
        for (int k = 1; k <= 33; k++) begin
            transact($sformatf("fill%0d", k), WIDTH'(k), 1'b1, 1'b0, 1'b1,
                     ADDR_WIDTH'((k - 1) % DEPTH), (ADDR_WIDTH+1)'((k > 32) ? 32 : k));
        end
        transact("look_key1", 32'd1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd32);
        transact("look_key33", 32'd33, 1'b0, 1'b1, 1'b0, 5'd0, 6'd32);
        transact("look_key32", 32'd32, 1'b0, 1'b1, 1'b0, 5'd31, 6'd32);

        // Backpressure: response held with a pending request waiting
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_key_i    = 32'd2;
        req_insert_i = 1'b0;
        @(posedge clk_i); #1;
        chk("hold.srch_en", 64'(cam_search_enable_o), 64'd1);
        @(posedge clk_i); #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("hold%0d.valid", c), 64'(rsp_valid_o), 64'd1);
            chk($sformatf("hold%0d.hit", c), 64'(rsp_hit_o), 64'd1);
            chk($sformatf("hold%0d.index", c), 64'(rsp_index_o), 64'd1);
            chk($sformatf("hold%0d.ready", c), 64'(req_ready_o), 64'd0);
            chk($sformatf("hold%0d.srch_en", c), 64'(cam_search_enable_o), 64'd0);
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        chk("hold.released", 64'(rsp_valid_o), 64'd0);

        // Reset in the middle of a write
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_key_i    = 32'h0000CAFE;
        req_insert_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rstwr.wr_en", 64'(cam_write_enable_o), 64'd1);
        chk("rstwr.wr_idx", 64'(cam_write_index_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("rstwr.wr_en_off", 64'(cam_write_enable_o), 64'd0);
        chk("rstwr.wr_idx_off", 64'(cam_write_index_o), 64'd0);
        chk("rstwr.wr_data_off", 64'(cam_write_data_o), 64'd0);
        chk("rstwr.occ", 64'(occupancy_o), 64'd0);
        chk("rstwr.rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rstwr.ready", 64'(req_ready_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        transact("post_rst_ins", 32'h0000CAFE, 1'b1, 1'b0, 1'b1, 5'd0, 6'd1);
        transact("post_rst_look", 32'h0000CAFE, 1'b0, 1'b1, 1'b0, 5'd0, 6'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cam_lookup_ctrl.md
# cam_lookup_ctrl

Request-side controller for the 32-entry content-addressable memory: accepts key requests over a valid/ready handshake, drives the CAM search port, and on a miss optionally allocates an entry through the CAM write port using FIFO (oldest-first) replacement. It returns hit/miss and the entry index over a response handshake. It sits between the client pipeline and the CAM and is the only master of the CAM search and write ports.

## Interface
- WIDTH, 32, key/data width; equals the CAM data width
- ADDR_WIDTH, 5, entry index width; CAM depth = 2**ADDR_WIDTH
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  controller can accept a request
- req_key_i  in  WIDTH  key to look up
- req_insert_i  in  1  1 = insert key on miss, 0 = lookup only
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  client accepts response
- rsp_hit_o  out  1  key was already present
- rsp_inserted_o  out  1  key was written this transaction
- rsp_index_o  out  ADDR_WIDTH  entry index (hit or inserted); 0 on plain miss
- cam_search_enable_o  out  1  CAM search strobe
- cam_search_data_o  out  WIDTH  CAM search key
- cam_search_valid_i  in  1  CAM match found (combinational from search inputs)
- cam_search_index_i  in  ADDR_WIDTH  CAM lowest matching index
- cam_write_enable_o  out  1  CAM write strobe
- cam_write_index_o  out  ADDR_WIDTH  CAM write row
- cam_write_data_o  out  WIDTH  CAM write data
- occupancy_o  out  ADDR_WIDTH+1  number of valid entries, 0..2**ADDR_WIDTH

## Operation
- States: IDLE, SEARCH, WRITE, RESP. Reset state IDLE.
- IDLE: req_ready_o=1 (0 while rst_i high). On req_valid_i&req_ready_o latch key and insert flag -> SEARCH.
- SEARCH (one cycle): cam_search_enable_o=1, cam_search_data_o=latched key; sample cam_search_valid_i/cam_search_index_i at cycle end.
  - hit -> RESP, rsp_hit_o=1, rsp_inserted_o=0, rsp_index_o=cam_search_index_i.
  - miss & insert -> WRITE.
  - miss & !insert -> RESP, hit=0, inserted=0, index=0.
- WRITE (one cycle): cam_write_enable_o=1, cam_write_index_o=victim pointer, cam_write_data_o=latched key. Then RESP, hit=0, inserted=1, index=victim pointer; victim pointer increments (wraps 2**ADDR_WIDTH-1 -> 0); occupancy increments, saturating at 2**ADDR_WIDTH.
- RESP: rsp_valid_o=1, response fields stable; on rsp_ready_i -> IDLE. No new request accepted in RESP (req_ready_o=0).
- Full (occupancy=2**ADDR_WIDTH): insert overwrites the oldest entry at the victim pointer; occupancy stays saturated.
- CAM strobes are 0 in every state other than their own; cam_*_data_o/index_o drive latched values at all times.
- Attached CAM shares rst_i; invalid rows never report a match.
- Reset (any state, any cycle): state IDLE, all outputs 0, victim pointer 0, occupancy 0; an in-flight write is abandoned.

## Timing
- Request accepted at edge N: SEARCH in cycle N+1; hit or lookup-miss: rsp_valid_o from N+2; insert-miss: write strobe in N+2, rsp_valid_o from N+3.
- Minimum request spacing: 3 cycles (hit) or 4 cycles (insert) with rsp_ready_i held high.
- Response held indefinitely while rsp_ready_i=0; no field changes until accepted.
- occupancy_o and victim pointer update on the edge ending WRITE; visible in RESP.
- All outputs registered or decoded from state only; no combinational path from req_* to cam_* or rsp_*.

## Test plan
- Reset then insert 0xDEADBEEF -> write strobe index 0 in cycle N+2, response hit=0 inserted=1 index=0 at N+3, occupancy=1.
- Repeat lookup of 0xDEADBEEF (insert=0) -> no write strobe, response hit=1 index=0 at N+2, occupancy unchanged.
- Lookup-only of absent 0x12345678 -> hit=0 inserted=0 index=0, no write, occupancy unchanged.
- Insert 33 distinct keys 1..33 -> indices 0..31 then 0; occupancy saturates at 32; lookup of key 1 misses, key 33 hits index 0.
- Hold rsp_ready_i=0 for 5 cycles with req_valid_i=1 -> response stable, req_ready_o=0, no second search strobe.
- Assert rst_i during WRITE -> outputs immediately 0, occupancy 0, next insert uses index 0.
